// File: rtl/dm_host_loader.sv
// Byte-link host for the processor core. It loads a data-memory image while holding the core in reset,
// runs the core until it reports done or times out, then streams a result window back out.
module dm_host_loader #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LOAD_LEN = 2,
  parameter int unsigned RES_BASE = 2,
  parameter int unsigned RES_LEN  = 1,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              dm_wr_en,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wr_data,
  input  logic [DATA_W-1:0] dm_rd_data,
  output logic              core_reset,
  input  logic              core_done,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned RUN_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  LOAD_LAST  = CNT_W'(LOAD_LEN - 1);
  localparam logic [CNT_W-1:0]  RES_LAST   = CNT_W'(RES_LEN - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST   = RUN_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] RES_BASE_A = ADDR_W'(RES_BASE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_READ  = 3'd4
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [RUN_W-1:0]  r_run_cnt;
  logic              r_timeout;

  logic              w_load_phase;
  logic              w_accept;

  // Sequencer: load -> one reset cycle -> run -> read back -> idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_run_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_wr_cnt  <= CNT_W'(1);
            r_timeout <= 1'b0;
            r_state   <= (LOAD_LEN == 1) ? S_START : S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            if (r_wr_cnt == LOAD_LAST) begin
              r_state <= S_START;
            end
          end
        end
        S_START: begin
          r_run_cnt <= '0;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          // done takes priority over a timeout landing in the same cycle
          if (core_done) begin
            r_timeout <= 1'b0;
            r_rd_cnt  <= '0;
            r_state   <= S_READ;
          end else if (r_run_cnt == RUN_LAST) begin
            r_timeout <= 1'b1;
            r_rd_cnt  <= '0;
            r_state   <= S_READ;
          end else begin
            r_run_cnt <= r_run_cnt + RUN_W'(1);
          end
        end
        S_READ: begin
          if (out_ready) begin
            if (r_rd_cnt == RES_LAST) begin
              r_rd_cnt <= '0;
              r_state  <= S_IDLE;
            end else begin
              r_rd_cnt <= r_rd_cnt + CNT_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gating with reset keeps the link closed while reset is held
  assign w_load_phase = reset && ((r_state == S_IDLE) || (r_state == S_LOAD));
  assign w_accept     = w_load_phase && in_valid;

  assign in_ready   = w_load_phase;
  assign dm_wr_en   = w_accept;
  assign dm_wr_data = w_accept ? in_data : '0;

  always_comb begin
    dm_addr = '0;
    if (r_state == S_LOAD) begin
      dm_addr = ADDR_W'(r_wr_cnt);
    end else if (r_state == S_READ) begin
      dm_addr = RES_BASE_A + ADDR_W'(r_rd_cnt);
    end
  end

  assign core_reset = (r_state != S_RUN);
  assign out_valid  = (r_state == S_READ);
  assign out_data   = out_valid ? dm_rd_data : '0;
  assign busy       = (r_state != S_IDLE);
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_dm_host_loader.sv
// Bench for dm_host_loader: behavioural data memory plus a core model that ANDs words 0 and 1 into 8'hFF.
// Read window FF,00,01 exercises address wrap and reads back the loaded image.
module tb_dm_host_loader;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       dm_wr_en;
  logic [7:0] dm_addr;
  logic [7:0] dm_wr_data;
  logic [7:0] dm_rd_data;
  logic       core_reset;
  logic       core_done;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       timeout;

  int         tests_run    = 0;
  int         tests_failed = 0;
  int         host_writes  = 0;
  int         core_cyc     = 0;
  int         done_at      = 1000;
  logic [7:0] mem [0:255];
  logic [7:0] exp_q [$];
  logic [7:0] last_ff;

  dm_host_loader #(
    .ADDR_W  (8),
    .DATA_W  (8),
    .LOAD_LEN(3),
    .RES_BASE(255),
    .RES_LEN (3),
    .TIMEOUT (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .dm_wr_en  (dm_wr_en),
    .dm_addr   (dm_addr),
    .dm_wr_data(dm_wr_data),
    .dm_rd_data(dm_rd_data),
    .core_reset(core_reset),
    .core_done (core_done),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory and core model: the core signals done after done_at+1 run cycles
  assign dm_rd_data = mem[dm_addr];
  assign core_done  = !core_reset && (core_cyc == done_at);

  always @(posedge clk) begin
    if (dm_wr_en) begin
      mem[dm_addr] <= dm_wr_data;
      host_writes  <= host_writes + 1;
    end
    if (core_done) mem[8'hFF] <= mem[0] & mem[1];
    core_cyc <= core_reset ? 0 : core_cyc + 1;
  end

  // Called at a negedge with the host idle; returns at the negedge where the host is in START
  task automatic send_image(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int gap);
    logic [7:0] bytes [3];
    bytes = '{b0, b1, b2};
    for (int i = 0; i < 3; i++) begin
      if (i == 1 && gap > 0) begin
        in_valid = 1'b0;
        in_data  = 8'hA5;
        repeat (gap) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = bytes[i];
      tests_run++;
      if (in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL load_ready[%0d]: got %b expected 1", i, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_run(input int exp_run, input logic exp_to);
    int n   = 0;
    int bad = 0;
    bit got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (core_reset) begin
        got = 1;
        break;
      end
      n++;
      if (dm_wr_en !== 1'b0 || dm_addr !== 8'h00) bad++;
    end
    tests_run++;
    if (!got || n != exp_run) begin
      tests_failed++;
      $display("FAIL run_cycles: got %0d (ended=%0d) expected %0d", n, got, exp_run);
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL run_port: %0d cycles with write or nonzero addr, expected 0", bad);
    end
    tests_run++;
    if (timeout !== exp_to || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL run_exit: timeout=%b out_valid=%b expected timeout=%b out_valid=1",
               timeout, out_valid, exp_to);
    end
  endtask

  task automatic read_results(input bit stall);
    logic [7:0] exp_b;
    logic [7:0] exp_a;
    logic [7:0] held;
    int         held_bad;
    for (int k = 0; k < 3; k++) begin
      if (exp_q.size() == 0) begin
        exp_b = 8'hxx;
      end else begin
        exp_b = exp_q.pop_front();
      end
      exp_a = 8'(255 + k);
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== exp_b || dm_addr !== exp_a) begin
        tests_failed++;
        $display("FAIL read[%0d]: valid=%b data=%h addr=%h expected valid=1 data=%h addr=%h",
                 k, out_valid, out_data, dm_addr, exp_b, exp_a);
      end
      if (stall) begin
        held     = out_data;
        held_bad = 0;
        repeat (4) begin
          @(negedge clk);
          if (out_valid !== 1'b1 || out_data !== held) held_bad++;
        end
        tests_run++;
        if (held_bad != 0) begin
          tests_failed++;
          $display("FAIL read_hold[%0d]: %0d unstable cycles expected 0", k, held_bad);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || core_reset !== 1'b1 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL back_idle: busy=%b out_valid=%b core_reset=%b in_ready=%b expected 0 0 1 1",
               busy, out_valid, core_reset, in_ready);
    end
  endtask

  task automatic run_image(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int gap, input int done_v, input int exp_run, input logic exp_to,
                           input bit stall, input bit junk);
    int         w0;
    logic [7:0] exp_ff;
    w0      = host_writes;
    done_at = done_v;
    send_image(b0, b1, b2, gap);
    exp_ff = exp_to ? last_ff : (b0 & b1);
    exp_q.push_back(exp_ff);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    tests_run++;
    if (host_writes - w0 != 3) begin
      tests_failed++;
      $display("FAIL load_writes: got %0d expected 3", host_writes - w0);
    end
    tests_run++;
    if ({core_reset, in_ready, busy, timeout} !== 4'b1010) begin
      tests_failed++;
      $display("FAIL start_state: got core_reset,in_ready,busy,timeout=%b expected 1010",
               {core_reset, in_ready, busy, timeout});
    end
    if (junk) begin
      in_valid = 1'b1;
      in_data  = 8'h5A;
    end
    wait_run(exp_run, exp_to);
    in_valid = 1'b0;
    read_results(stall);
    last_ff = exp_ff;
    tests_run++;
    if (host_writes - w0 != 3) begin
      tests_failed++;
      $display("FAIL total_writes: got %0d expected 3", host_writes - w0);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({in_ready, dm_wr_en, core_reset, out_valid, busy, timeout} !== 6'b001000) begin
      tests_failed++;
      $display("FAIL reset_ctl: in_ready,wr_en,core_reset,out_valid,busy,timeout=%b expected 001000",
               {in_ready, dm_wr_en, core_reset, out_valid, busy, timeout});
    end
    tests_run++;
    if (dm_addr !== 8'h00 || dm_wr_data !== 8'h00 || out_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data: addr=%h wr_data=%h out_data=%h expected 00 00 00",
               dm_addr, dm_wr_data, out_data);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    tests_run++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || host_writes != 0) begin
      tests_failed++;
      $display("FAIL reset_release: in_ready=%b busy=%b writes=%0d expected 1 0 0",
               in_ready, busy, host_writes);
    end
  endtask

  task automatic test_and_program();
    run_image(8'h00, 8'h1E, 8'h33, 0, 3, 4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_pressure();
    run_image(8'hC3, 8'hAF, 8'h11, 3, 7, 8, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_timeout();
    run_image(8'h12, 8'h34, 8'h56, 0, 1000, 16, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (timeout !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_sticky: got %b expected 1", timeout);
    end
  endtask

  task automatic test_done_tie();
    run_image(8'h6E, 8'hDB, 8'h01, 0, 15, 16, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    done_at = 1000;
    send_image(8'h77, 8'h88, 8'h99, 0);
    repeat (5) @(negedge clk);
    tests_run++;
    if (core_reset !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_run_state: core_reset=%b expected 0", core_reset);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({core_reset, out_valid, busy, in_ready} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL mid_run_reset: core_reset,out_valid,busy,in_ready=%b expected 1000",
               {core_reset, out_valid, busy, in_ready});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    done_at = 2;
    send_image(8'hF5, 8'h3F, 8'h00, 0);
    wait_run(3, 1'b0);
    last_ff = 8'hF5 & 8'h3F;
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({core_reset, out_valid, busy} !== 3'b100 || out_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_read_reset: core_reset,out_valid,busy=%b out_data=%h expected 100 00",
               {core_reset, out_valid, busy}, out_data);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_image(8'hF0, 8'h3C, 8'h77, 0, 0, 1, 1'b0, 1'b0, 1'b0);
    run_image(8'hAA, 8'h0F, 8'h55, 0, 5, 6, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    last_ff   = 8'h00;
    test_reset();
    test_and_program();
    test_back_pressure();
    test_timeout();
    test_done_tie();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d checks done", tests_run);
    $fatal(1);
  end

endmodule
